// File: rtl/expr_char_tx.sv
// ---------------------------------------------------------------------------
// expr_char_tx
//   Transmitter for the ASCII character stream consumed by the pattern-
//   matching FSMs. On an accepted start it latches two hex digits and an
//   operator, then serialises "A<op>B=" one 8-bit character per accepted
//   beat under a valid/ready handshake, so a stalling consumer loses nothing.
//
//   Optional feature (compile-time macro SPACE_PAD_EN):
//     defined   -> one ' ' is inserted after A and after op ("A op B=", 6 chars)
//     undefined -> compact stream "A<op>B=" (4 chars)
//
// Parameters
//   IDLE_CHAR  character driven on out_char while nothing is offered
//   LOWER_HEX  1: digits 10-15 as 'a'-'f'; 0: as 'A'-'F'
//
// Ports
//   clk        clock, all state updates on posedge
//   clr        synchronous active-high reset
//   start      request one expression (only honoured while idle)
//   op_a       left operand digit, latched on accepted start
//   op_sel     operator: 00 '+', 01 '-', 10 '*', 11 '/'
//   op_b       right operand digit, latched on accepted start
//   out_ready  consumer can take out_char this cycle
//   out_char   registered ASCII character offered
//   out_valid  registered, out_char is valid
//   busy       registered, high from accepted start until '=' is accepted
//   done       registered, one-cycle pulse after '=' is accepted
// ---------------------------------------------------------------------------
module expr_char_tx #(
    parameter logic [7:0] IDLE_CHAR = 8'h20,
    parameter int         LOWER_HEX = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [1:0] op_sel,
    input  logic [3:0] op_b,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

`ifdef SPACE_PAD_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CH_A  = 3'd1,
        S_SP1   = 3'd2,
        S_CH_OP = 3'd3,
        S_SP2   = 3'd4,
        S_CH_B  = 3'd5,
        S_CH_EQ = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CH_A  = 3'd1,
        S_CH_OP = 3'd3,
        S_CH_B  = 3'd5,
        S_CH_EQ = 3'd6
    } state_t;
`endif

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [7:0] EQ_CHAR    = 8'h3D;

    state_t     state;
    logic [3:0] lat_a;
    logic [1:0] lat_sel;
    logic [3:0] lat_b;
    logic       beat;

    // Hex digit to ASCII, case of A-F chosen by LOWER_HEX.
    function automatic logic [7:0] hex_char(input logic [3:0] d);
        logic [7:0] c;
        if (d < 4'd10) begin
            c = 8'h30 + {4'h0, d};
        end else begin
            c = ((LOWER_HEX != 0) ? 8'h61 : 8'h41) + {4'h0, d - 4'd10};
        end
        return c;
    endfunction

    // Operator code to ASCII.
    function automatic logic [7:0] op_char(input logic [1:0] s);
        logic [7:0] c;
        case (s)
            2'b00:   c = 8'h2B;
            2'b01:   c = 8'h2D;
            2'b10:   c = 8'h2A;
            2'b11:   c = 8'h2F;
            default: c = 8'h2B;
        endcase
        return c;
    endfunction

    // A character leaves only when it is both offered and taken.
    assign beat = out_valid & out_ready;

    // Sequencer: each transition also loads the next character, so the
    // outputs are registered and back-to-back beats give one char per cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            lat_a     <= 4'h0;
            lat_sel   <= 2'b00;
            lat_b     <= 4'h0;
            out_char  <= IDLE_CHAR;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_a     <= op_a;
                        lat_sel   <= op_sel;
                        lat_b     <= op_b;
                        state     <= S_CH_A;
                        out_char  <= hex_char(op_a);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CH_A: begin
                    if (beat) begin
`ifdef SPACE_PAD_EN
                        state    <= S_SP1;
                        out_char <= SPACE_CHAR;
`else
                        state    <= S_CH_OP;
                        out_char <= op_char(lat_sel);
`endif
                    end
                end
`ifdef SPACE_PAD_EN
                S_SP1: begin
                    if (beat) begin
                        state    <= S_CH_OP;
                        out_char <= op_char(lat_sel);
                    end
                end
`endif
                S_CH_OP: begin
                    if (beat) begin
`ifdef SPACE_PAD_EN
                        state    <= S_SP2;
                        out_char <= SPACE_CHAR;
`else
                        state    <= S_CH_B;
                        out_char <= hex_char(lat_b);
`endif
                    end
                end
`ifdef SPACE_PAD_EN
                S_SP2: begin
                    if (beat) begin
                        state    <= S_CH_B;
                        out_char <= hex_char(lat_b);
                    end
                end
`endif
                S_CH_B: begin
                    if (beat) begin
                        state    <= S_CH_EQ;
                        out_char <= EQ_CHAR;
                    end
                end
                S_CH_EQ: begin
                    if (beat) begin
                        state     <= S_IDLE;
                        out_char  <= IDLE_CHAR;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_char  <= IDLE_CHAR;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
